stream_demux1to2: RTL and testbench

- Dataflow 1-to-2 demultiplexer (steer) for the fabric datapath: the routing counterpart of mux2to1.
- Consumes one data token plus one select token per transfer and routes the data to out0 (sel=0) or out1 (sel=1).
- Each output has its own DEPTH-entry FIFO, so one stalled consumer never blocks tokens bound for the other.
- Sits between a producer PE and two consumer PEs on valid/ready links.

---
 rtl/stream_demux1to2.sv | 142 ++++++++++++++
 tb/tb_stream_demux1to2.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux1to2.sv
// rtl/stream_demux1to2.sv - 1-to-2 dataflow steer with one FIFO per output
//
// Purpose: takes one data token and one select token together, and writes the
// data into the out0 FIFO (sel=0) or the out1 FIFO (sel=1). Each output has its
// own DEPTH-entry FIFO, so a stalled consumer never blocks the other output.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_data/in_ready       data token input
//   sel_valid/sel/sel_ready         select token input
//   out0_valid/out0_data/out0_ready output 0 (head of FIFO 0)
//   out1_valid/out1_data/out1_ready output 1 (head of FIFO 1)
//   cnt0, cnt1            16-bit fire counters per output
//                         (present only with STREAM_DEMUX_STATS_EN defined)
module stream_demux1to2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             sel_valid,
  input  logic             sel,
  output logic             sel_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q   [2][DEPTH];
  logic [WIDTH-1:0] mem_d   [2][DEPTH];
  logic [PW-1:0]    wptr_q  [2];
  logic [PW-1:0]    wptr_d  [2];
  logic [PW-1:0]    rptr_q  [2];
  logic [PW-1:0]    rptr_d  [2];
  logic [CW-1:0]    count_q [2];
  logic [CW-1:0]    count_d [2];
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             full_sel;
  logic             fire;

  always_comb begin
    // Readiness looks only at registered occupancy: a full FIFO refuses a push
    // even when it pops this cycle, so out*_ready never reaches in_ready.
    full[0]   = (count_q[0] == FULL_CNT);
    full[1]   = (count_q[1] == FULL_CNT);
    full_sel  = full[sel];
    in_ready  = sel_valid & ~full_sel;
    sel_ready = in_valid & ~full_sel;
    fire      = in_valid & sel_valid & ~full_sel;
    push      = {fire & sel, fire & ~sel};
    pop[0]    = (count_q[0] != '0) & out0_ready;
    pop[1]    = (count_q[1] != '0) & out1_ready;

    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (push[0]) begin
      mem_d[0][wptr_q[0]] = in_data;
      wptr_d[0]           = wptr_q[0] + 1'b1;
    end
    if (push[1]) begin
      mem_d[1][wptr_q[1]] = in_data;
      wptr_d[1]           = wptr_q[1] + 1'b1;
    end
    if (pop[0]) rptr_d[0] = rptr_q[0] + 1'b1;
    if (pop[1]) rptr_d[1] = rptr_q[1] + 1'b1;

    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push[0], pop[0]})
      2'b10:   count_d[0] = count_q[0] + 1'b1;
      2'b01:   count_d[0] = count_q[0] - 1'b1;
      default: count_d[0] = count_q[0];
    endcase
    case ({push[1], pop[1]})
      2'b10:   count_d[1] = count_q[1] + 1'b1;
      2'b01:   count_d[1] = count_q[1] - 1'b1;
      default: count_d[1] = count_q[1];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '{default: '0};
      rptr_q  <= '{default: '0};
      count_q <= '{default: '0};
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Heads are masked to zero while empty; since count_q clears asynchronously
  // the outputs drop to zero the moment reset rises.
  assign out0_valid = (count_q[0] != '0);
  assign out1_valid = (count_q[1] != '0);
  assign out0_data  = out0_valid ? mem_q[0][rptr_q[0]] : '0;
  assign out1_data  = out1_valid ? mem_q[1][rptr_q[1]] : '0;

`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];

  always_comb begin
    cnt_d[0] = cnt_q[0] + {15'd0, push[0]};
    cnt_d[1] = cnt_q[1] + {15'd0, push[1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_stream_demux1to2.sv
// tb/tb_stream_demux1to2.sv - scoreboard bench for stream_demux1to2
module tb_stream_demux1to2;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sel_valid;
  logic             sel;
  logic             sel_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;
  logic [15:0]      fires0 = '0;
  logic [15:0]      fires1 = '0;
`endif

  stream_demux1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sel_valid(sel_valid), .sel(sel), .sel_ready(sel_ready),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready)
`ifdef STREAM_DEMUX_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp0[$];
  logic [WIDTH-1:0] exp1[$];
  bit room;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled at negedge, i.e. the handshake state for the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("out0_valid", WIDTH'(out0_valid), WIDTH'(exp0.size() != 0));
      chk("out1_valid", WIDTH'(out1_valid), WIDTH'(exp1.size() != 0));
      chk("out0_data", out0_data, (exp0.size() != 0) ? exp0[0] : '0);
      chk("out1_data", out1_data, (exp1.size() != 0) ? exp1[0] : '0);
      room = sel ? (exp1.size() < DEPTH) : (exp0.size() < DEPTH);
      chk("in_ready", WIDTH'(in_ready), WIDTH'(sel_valid & room));
      chk("sel_ready", WIDTH'(sel_ready), WIDTH'(in_valid & room));
`ifdef STREAM_DEMUX_STATS_EN
      chk("cnt0", WIDTH'(cnt0), WIDTH'(fires0));
      chk("cnt1", WIDTH'(cnt1), WIDTH'(fires1));
`endif
      if (exp0.size() != 0 && out0_ready) void'(exp0.pop_front());
      if (exp1.size() != 0 && out1_ready) void'(exp1.pop_front());
      if (in_valid && sel_valid && room) begin
        if (sel) exp1.push_back(in_data);
        else     exp0.push_back(in_data);
`ifdef STREAM_DEMUX_STATS_EN
        if (sel) fires1 = fires1 + 16'd1;
        else     fires0 = fires0 + 16'd1;
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 0; in_data = '0; sel_valid = 0; sel = 0;
    out0_ready = 0; out1_ready = 0;
    tick(); tick();
    chk("rst_out0_valid", WIDTH'(out0_valid), '0);
    chk("rst_out1_valid", WIDTH'(out1_valid), '0);
    chk("rst_out0_data", out0_data, '0);
    chk("rst_out1_data", out1_data, '0);
    reset = 1'b0;
    tick();

    // Single route to out0
    in_data = 32'hA5A5A5A5; sel = 0; in_valid = 1; sel_valid = 1;
    tick();
    in_valid = 0; sel_valid = 0; #1;
    chk("single_out0_valid", WIDTH'(out0_valid), 1);
    chk("single_out0_data", out0_data, 32'hA5A5A5A5);
    chk("single_out1_valid", WIDTH'(out1_valid), 0);
    out0_ready = 1; tick(); out0_ready = 0; tick();

    // Alternating stream with both consumers ready
    out0_ready = 1; out1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sel = i[0]; in_data = WIDTH'(i + 1); in_valid = 1; sel_valid = 1;
      tick();
      if (i == 1) begin
        #1;
        chk("alt_out1_data", out1_data, 2);
      end
    end
    in_valid = 0; sel_valid = 0;
    tick(); tick();
    out0_ready = 0; out1_ready = 0;

    // Backpressure isolation
    for (int i = 0; i < 2; i++) begin
      sel = 0; in_data = WIDTH'(10 + i); in_valid = 1; sel_valid = 1;
      tick();
    end
    in_data = 12; #1;
    chk("bp_in_ready", WIDTH'(in_ready), 0);
    chk("bp_sel_ready", WIDTH'(sel_ready), 0);
    sel = 1; in_data = 9; #1;
    chk("bp_other_in_ready", WIDTH'(in_ready), 1);
    tick();
    in_valid = 0; sel_valid = 0; #1;
    chk("bp_out1_data", out1_data, 9);
    chk("bp_out0_data", out0_data, 10);
    out0_ready = 1; out1_ready = 1;
    tick(); tick(); tick();
    out0_ready = 0; out1_ready = 0;

    // Token pairing: data without select never fires
    sel = 0; in_data = 32'h77; in_valid = 1; sel_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pair_in_ready", WIDTH'(in_ready), 0);
      chk("pair_out0_valid", WIDTH'(out0_valid), 0);
    end
    sel_valid = 1;
    tick();
    in_valid = 0; sel_valid = 0; #1;
    chk("pair_one_fire", out0_data, 32'h77);
    out0_ready = 1; tick();
    chk("pair_exactly_one", WIDTH'(out0_valid), 0);
    out0_ready = 0;

    // Reset mid-operation with both FIFOs full
    for (int i = 0; i < 4; i++) begin
      sel = i[1]; in_data = WIDTH'(32'h100 + i); in_valid = 1; sel_valid = 1;
      tick();
    end
    in_valid = 0; sel_valid = 0;
    #2; reset = 1'b1; #1;
    chk("mid_rst_out0_valid", WIDTH'(out0_valid), 0);
    chk("mid_rst_out1_valid", WIDTH'(out1_valid), 0);
    chk("mid_rst_out0_data", out0_data, 0);
    chk("mid_rst_out1_data", out1_data, 0);
    exp0.delete(); exp1.delete();
`ifdef STREAM_DEMUX_STATS_EN
    fires0 = '0; fires1 = '0;
`endif
    tick();
    reset = 1'b0;
    out0_ready = 1; out1_ready = 1;
    tick(); tick();
    chk("post_rst_no_stale0", WIDTH'(out0_valid), 0);
    chk("post_rst_no_stale1", WIDTH'(out1_valid), 0);
    out0_ready = 0; out1_ready = 0;

    // Full FIFO refuses a push even while popping
    for (int i = 0; i < 2; i++) begin
      sel = 1; in_data = WIDTH'(21 + i); in_valid = 1; sel_valid = 1;
      tick();
    end
    out1_ready = 1; in_data = 23; #1;
    chk("fullpop_refused", WIDTH'(in_ready), 0);
    tick();
    chk("fullpop_accept", WIDTH'(in_ready), 1);
    chk("fullpop_head", out1_data, 22);
    tick();
    in_valid = 0; sel_valid = 0; #1;
    chk("fullpop_new_head", out1_data, 23);
    tick(); tick();
    chk("fullpop_drained", WIDTH'(out1_valid), 0);

    out0_ready = 1; out1_ready = 1;
    tick(); tick();
    chk("sb_empty0", WIDTH'(exp0.size()), 0);
    chk("sb_empty1", WIDTH'(exp1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
